koios_axi_tg: RTL

- Stream initiator and response checker that drives the input side of a Koios AXI-stream PE wrapper and consumes its output side.
- Issues a programmed number of LFSR-data packets with incrementing dest/id, tracks outstanding requests, and checks each returned dest/id against the expected transform (dest+2, id+1).
- Reports a completion flag, error count, receive count, timeout flag and data signature for self-checking bring-up runs.

---
 rtl/koios_axi_tg.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/koios_axi_tg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : koios_axi_tg
//  Purpose  : Stream traffic generator and response checker for a Koios
//             AXI-stream PE wrapper. Issues LFSR-data packets with
//             incrementing dest/id and checks each response against the
//             expected transform (dest+2, id+1).
//  Revision : 1.0 - initial release
// ============================================================================
module koios_axi_tg #(
  parameter int          AXI_DATAW   = 128,
  parameter int          MAX_OUT     = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_1234
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          num_pkts,
  output logic [AXI_DATAW-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [3:0]           tx_dest,
  output logic [1:0]           tx_id,
  input  logic [AXI_DATAW-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [3:0]           rx_dest,
  input  logic [1:0]           rx_id,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [15:0]          err_count,
  output logic [15:0]          rx_count,
  output logic [31:0]          signature
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SEND  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam int NREP = AXI_DATAW / 32;
  localparam int PW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW   = $clog2(MAX_OUT + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] c_MAX_OUT   = CW'(MAX_OUT);
  localparam logic [TW-1:0] c_TIMEOUT   = TW'(TIMEOUT_CYC);
  localparam logic [PW-1:0] c_PTR_LAST  = PW'(MAX_OUT - 1);
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0]   c_LFSR_TAPS = 32'h8020_0003;

  logic [1:0]           state_q, state_d;
  logic [15:0]          num_q, num_d;
  logic [15:0]          sent_q, sent_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [15:0]          err_q, err_d;
  logic [15:0]          rxc_q, rxc_d;
  logic [31:0]          sig_q, sig_d;
  logic                 to_q, to_d;
  logic                 done_q, done_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [AXI_DATAW-1:0] tx_data_q, tx_data_d;
  logic [3:0]           tx_dest_q, tx_dest_d;
  logic [1:0]           tx_id_q, tx_id_d;
  logic                 rx_ready_q, rx_ready_d;
  logic [5:0]           fifo_q [MAX_OUT];

  logic                 w_tx_fire;
  logic                 w_rx_fire;
  logic                 w_busy;
  logic                 w_push;
  logic                 w_pop;
  logic [5:0]           w_push_entry;
  logic [5:0]           w_exp;

  function automatic logic [31:0] f_lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? c_LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Upper response data lanes do not feed the signature
  generate
    if (AXI_DATAW > 32) begin : g_rx_hi
      logic w_unused_rx_hi;
      assign w_unused_rx_hi = ^rx_data[AXI_DATAW-1:32];
    end
  endgenerate

  assign w_tx_fire    = tx_valid_q & tx_ready;
  assign w_rx_fire    = rx_valid & rx_ready_q;
  assign w_busy       = (state_q == c_SEND) || (state_q == c_DRAIN);
  assign w_push       = w_tx_fire;
  assign w_pop        = w_rx_fire && (occ_q != '0);
  assign w_push_entry = {tx_dest_q + 4'd2, tx_id_q + 2'd1};
  assign w_exp        = fifo_q[rptr_q];

  // Next-state logic: handshakes, run control, timeout and request presentation
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    sent_d     = sent_q;
    lfsr_d     = lfsr_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;
    rxc_d      = rxc_q;
    sig_d      = sig_q;
    to_d       = to_q;
    done_d     = done_q;
    tx_data_d  = tx_data_q;
    tx_dest_d  = tx_dest_q;
    tx_id_d    = tx_id_q;

    if (w_tx_fire) begin
      sent_d = sent_q + 16'd1;
      lfsr_d = f_lfsr_next(lfsr_q);
      wptr_d = f_ptr_inc(wptr_q);
    end

    if (w_rx_fire) begin
      rxc_d = f_sat_inc(rxc_q);
      sig_d = {sig_q[30:0], sig_q[31]} ^ rx_data[31:0];
      if (occ_q == '0) begin
        err_d = f_sat_inc(err_q);
      end else begin
        rptr_d = f_ptr_inc(rptr_q);
        if ({rx_dest, rx_id} != w_exp) begin
          err_d = f_sat_inc(err_q);
        end
      end
    end

    // Simultaneous push and pop cancel in the occupancy count
    case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    if (w_tx_fire || w_rx_fire) begin
      tcnt_d = '0;
    end else if (w_busy && (occ_q != '0)) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    case (state_q)
      c_IDLE, c_DONE: begin
        if (start) begin
          num_d  = num_pkts;
          sent_d = '0;
          lfsr_d = LFSR_SEED;
          wptr_d = '0;
          rptr_d = '0;
          occ_d  = '0;
          tcnt_d = '0;
          err_d  = '0;
          rxc_d  = '0;
          sig_d  = '0;
          to_d   = 1'b0;
          if (num_pkts == 16'd0) begin
            state_d = c_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = c_SEND;
            done_d  = 1'b0;
          end
        end
      end
      c_SEND: begin
        if (sent_d == num_q) begin
          state_d = c_DRAIN;
        end
      end
      c_DRAIN: begin
        if (occ_q == '0) begin
          state_d = c_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = c_IDLE;
    endcase

    // A stuck responder ends the run
    if (w_busy && (tcnt_d == c_TIMEOUT)) begin
      state_d = c_DONE;
      done_d  = 1'b1;
      to_d    = 1'b1;
    end

    tx_valid_d = (state_d == c_SEND) && (sent_d < num_d) && (occ_d < c_MAX_OUT);
    rx_ready_d = (state_d == c_SEND) || (state_d == c_DRAIN);

    // Request fields hold while stalled, reload after a handshake or a gap
    if (!tx_valid_d) begin
      tx_data_d = '0;
      tx_dest_d = '0;
      tx_id_d   = '0;
    end else if (!(tx_valid_q && !tx_ready)) begin
      tx_data_d = {NREP{lfsr_d}};
      tx_dest_d = sent_d[3:0];
      tx_id_d   = sent_d[1:0];
    end
  end

  // Control, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= c_IDLE;
      num_q      <= '0;
      sent_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      tcnt_q     <= '0;
      err_q      <= '0;
      rxc_q      <= '0;
      sig_q      <= '0;
      to_q       <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_dest_q  <= '0;
      tx_id_q    <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      sent_q     <= sent_d;
      lfsr_q     <= lfsr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      rxc_q      <= rxc_d;
      sig_q      <= sig_d;
      to_q       <= to_d;
      done_q     <= done_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_dest_q  <= tx_dest_d;
      tx_id_q    <= tx_id_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // Expected {dest, id} storage, written on every accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (w_push) begin
      fifo_q[wptr_q] <= w_push_entry;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_dest   = tx_dest_q;
  assign tx_id     = tx_id_q;
  assign rx_ready  = rx_ready_q;
  assign busy      = w_busy;
  assign done      = done_q;
  assign timeout   = to_q;
  assign err_count = err_q;
  assign rx_count  = rxc_q;
  assign signature = sig_q;

endmodule
`default_nettype wire
